// File: rtl/clk_switch_ctrl.sv
// Select controller for the glitch-free clk1/clk2 mux feeding the SHA-256 core.
// Define CLK_SWITCH_COUNT_EN to add the saturating completed-switch counter output switch_cnt.
module clk_switch_ctrl #(
  parameter int MIN_DWELL = 8,
  parameter int SETTLE    = 6,
  parameter int IDLE_HOLD = 16,
  parameter int CNTW      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fast_req,
  input  logic        force_slow,
  output logic        sel_clk2,
  output logic        fast_ack,
  output logic        switching
`ifdef CLK_SWITCH_COUNT_EN
  ,
  output logic [15:0] switch_cnt
`endif
);

  localparam logic [CNTW-1:0] DWELL_MAX   = CNTW'(MIN_DWELL);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] IDLE_LAST   = CNTW'(IDLE_HOLD - 1);
  localparam logic [CNTW-1:0] ONE         = CNTW'(1);

  typedef enum logic [2:0] {
    SLOW    = 3'd0,
    TO_FAST = 3'd1,
    FAST    = 3'd2,
    HOLD    = 3'd3,
    TO_SLOW = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] dwell_q, dwell_d;
  logic [CNTW-1:0] settle_q, settle_d;
  logic [CNTW-1:0] idle_q, idle_d;
  logic            sel_q, sel_d;
  logic            ack_q, ack_d;
  logic            sw_q, sw_d;
  logic            dwell_done;

  assign dwell_done = (dwell_q == DWELL_MAX);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idle_d   = idle_q;
    case (state_q)
      SLOW: begin
        if (fast_req && !force_slow && dwell_done) begin
          state_d  = TO_FAST;
          settle_d = '0;
        end
      end
      TO_FAST: begin
        if (settle_q == SETTLE_LAST) state_d = FAST;
        else                         settle_d = settle_q + ONE;
      end
      FAST: begin
        if (force_slow && dwell_done) begin
          state_d  = TO_SLOW;
          settle_d = '0;
        end else if (!fast_req) begin
          state_d = HOLD;
          idle_d  = '0;
        end
      end
      HOLD: begin
        // A request reasserting on the expiry cycle wins: no switch happens.
        if (fast_req && !force_slow) begin
          state_d = FAST;
        end else if ((force_slow || idle_q == IDLE_LAST) && dwell_done) begin
          state_d  = TO_SLOW;
          settle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
          idle_d = idle_q + ONE;
        end
      end
      TO_SLOW: begin
        if (settle_q == SETTLE_LAST) state_d = SLOW;
        else                         settle_d = settle_q + ONE;
      end
      default: state_d = SLOW;
    endcase

    sel_d = (state_d == TO_FAST) || (state_d == FAST) || (state_d == HOLD);
    ack_d = (state_d == FAST) || (state_d == HOLD);
    sw_d  = (state_d == TO_FAST) || (state_d == TO_SLOW);

    // Dwell restarts on every select edge so consecutive toggles are spaced.
    if (sel_d != sel_q)  dwell_d = '0;
    else if (dwell_done) dwell_d = dwell_q;
    else                 dwell_d = dwell_q + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SLOW;
      dwell_q  <= '0;
      settle_q <= '0;
      idle_q   <= '0;
      sel_q    <= 1'b0;
      ack_q    <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      settle_q <= settle_d;
      idle_q   <= idle_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      sw_q     <= sw_d;
    end
  end

  assign sel_clk2  = sel_q;
  assign fast_ack  = ack_q;
  assign switching = sw_q;

`ifdef CLK_SWITCH_COUNT_EN
  logic [15:0] cnt_q;
  logic        done_evt;

  assign done_evt = ((state_q == TO_FAST) && (state_d == FAST)) ||
                    ((state_q == TO_SLOW) && (state_d == SLOW));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          cnt_q <= '0;
    else if (done_evt && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign switch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed and randomized checks of clk_switch_ctrl against a timer-based reference model.
module tb_clk_switch_ctrl;

  localparam int MIN_DWELL = 8;
  localparam int SETTLE    = 6;
  localparam int IDLE_HOLD = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fast_req;
  logic        force_slow;
  logic        sel_clk2;
  logic        fast_ack;
  logic        switching;
  logic [15:0] switch_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: select/ack levels plus simple timers.
  bit m_sel, m_ack, m_hold;
  int m_since, m_busy, m_idle, m_done;
  // Property tracking on DUT outputs.
  int cyc, last_tog;
  bit have_tog;
  logic prev_sel;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .MIN_DWELL(MIN_DWELL), .SETTLE(SETTLE), .IDLE_HOLD(IDLE_HOLD), .CNTW(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fast_req   (fast_req),
    .force_slow (force_slow),
    .sel_clk2   (sel_clk2),
    .fast_ack   (fast_ack),
    .switching  (switching)
`ifdef CLK_SWITCH_COUNT_EN
    ,
    .switch_cnt (switch_cnt)
`endif
  );

`ifndef CLK_SWITCH_COUNT_EN
  assign switch_cnt = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_ack = 0; m_hold = 0;
    m_since = 0; m_busy = 0; m_idle = 0; m_done = 0;
    have_tog = 0; prev_sel = 1'b0;
  endtask

  task automatic model_drop(output bit tog);
    m_sel = 0; m_ack = 0; m_hold = 0; m_busy = SETTLE; tog = 1;
  endtask

  task automatic model_step(input logic fr, input logic fs);
    bit ok;
    bit tog;
    ok  = (m_since >= MIN_DWELL);
    tog = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_sel) m_ack = 1;
        if (m_done != 65535) m_done++;
      end
    end else if (!m_sel) begin
      if (fr && !fs && ok) begin
        m_sel = 1; m_busy = SETTLE; tog = 1;
      end
    end else if (!m_hold) begin
      if (fs && ok) model_drop(tog);
      else if (!fr) begin m_hold = 1; m_idle = 0; end
    end else begin
      if (fr && !fs) m_hold = 0;
      else if ((fs || m_idle == IDLE_HOLD - 1) && ok) model_drop(tog);
      else if (m_idle < IDLE_HOLD - 1) m_idle++;
    end
    if (tog)                   m_since = 0;
    else if (m_since < MIN_DWELL) m_since++;
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic tick();
    model_step(fast_req, force_slow);
    @(posedge clk);
    #1;
    cyc++;
    check("sel_model", sel_clk2, m_sel);
    check("ack_model", fast_ack, m_ack);
    check("sw_model", switching, (m_busy > 0));
    check("ack_implies_sel", fast_ack & ~sel_clk2, 0);
`ifdef CLK_SWITCH_COUNT_EN
    check("switch_cnt", switch_cnt, m_done);
`endif
    if (sel_clk2 !== prev_sel) begin
      if (have_tog) check("dwell_interval", (cyc - last_tog) >= MIN_DWELL, 1);
      have_tog = 1;
      last_tog = cyc;
      prev_sel = sel_clk2;
    end
  endtask

  // fast_req held from reset release: sel on edge 9, ack on edge 15, switching edges 9..14.
  task automatic first_switch();
    @(negedge clk);
    reset_n  = 1'b1;
    fast_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("first_sel", sel_clk2, (k >= 9));
      check("first_ack", fast_ack, (k >= 15));
      check("first_sw", switching, (k >= 9 && k <= 14));
    end
  endtask

  initial begin
    int fall_at, sw_cycles;
    bit found;
    reset_n    = 1'b0;
    fast_req   = 1'b0;
    force_slow = 1'b0;
    cyc        = 0;
    last_tog   = 0;
    model_reset();
    #1;
    check("rst_sel", sel_clk2, 0);
    check("rst_ack", fast_ack, 0);
    check("rst_sw", switching, 0);
    repeat (3) @(posedge clk);

    first_switch();

    repeat (5) tick();
    // Short request gap stays in the fast clock.
    fast_req = 1'b0;
    repeat (10) begin
      tick();
      check("gap_sel", sel_clk2, 1);
      check("gap_ack", fast_ack, 1);
      check("gap_sw", switching, 0);
    end
    fast_req = 1'b1;
    repeat (3) tick();

    // Permanent drop: fall 16 edges after HOLD entry, 6 cycles of switching.
    fast_req  = 1'b0;
    fall_at   = 0;
    sw_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sel_clk2 === 1'b0 && fall_at == 0) fall_at = i;
      if (switching === 1'b1) sw_cycles++;
    end
    check("idle_fall_edge", fall_at, 17);
    check("idle_sw_cycles", sw_cycles, SETTLE);
    check("idle_end_ack", fast_ack, 0);

    // Software override while requesting.
    fast_req = 1'b1;
    repeat (30) tick();
    force_slow = 1'b1;
    tick();
    check("force_sel", sel_clk2, 0);
    check("force_ack", fast_ack, 0);
    check("force_sw", switching, 1);
    repeat (20) begin
      tick();
      check("force_hold_sel", sel_clk2, 0);
    end
    force_slow = 1'b0;
    repeat (12) tick();

    // Random phase: fast_req toggles every 2 cycles, force_slow sporadic.
    for (int i = 0; i < 1000; i++) begin
      fast_req   = ~fast_req;
      force_slow = ($urandom_range(0, 7) == 0);
      repeat (2) tick();
    end

    // Asynchronous reset in the middle of TO_FAST.
    fast_req   = 1'b0;
    force_slow = 1'b0;
    repeat (40) tick();
    fast_req = 1'b1;
    found    = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (switching === 1'b1 && sel_clk2 === 1'b1 && fast_ack === 1'b0) found = 1;
    end
    check("to_fast_reached", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_sel", sel_clk2, 0);
    check("async_ack", fast_ack, 0);
    check("async_sw", switching, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_sel", sel_clk2, 0);
    first_switch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
